// File: rtl/multi_ratio_pulse_sched.sv
// multi_ratio_pulse_sched
// Source-domain scheduler that shares one multi-ratio pulse synchronizer
// between NUM_REQ requesters. Request pulses are queued in saturating
// per-requester pending counters. Winners are picked round-robin. Each winner
// gets one single-cycle sync_pulse. The pulse is followed by a stretch window
// (HOLD) and a guard gap (GAP), so every event reaches the destination domain
// as a distinct edge. All outputs come straight from registers.
module multi_ratio_pulse_sched #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int CTR_WIDTH = 10,
  parameter int PEND_W    = 3
) (
  input  logic                 clk_src,
  input  logic                 rst_n_src,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_pulse,
  input  logic [CTR_WIDTH-1:0] cfg_stretch_val,
  input  logic [CTR_WIDTH-1:0] cfg_gap_val,
  input  logic [NUM_REQ-1:0]   ovf_clr,
  output logic                 sync_pulse,
  output logic [ID_W-1:0]      sync_id,
  output logic [CTR_WIDTH-1:0] stretch_val_out,
  output logic                 busy,
  output logic                 pending_any,
  output logic [NUM_REQ-1:0]   overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0]    PEND_MAX = {PEND_W{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
  localparam logic [ID_W-1:0]      LAST_RST = ID_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [CTR_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [CTR_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [PEND_W-1:0]    pend_q [NUM_REQ];
  logic [PEND_W-1:0]    pend_d [NUM_REQ];
  logic [NUM_REQ-1:0]   ovf_q, ovf_d, ovf_set;

  logic                 sync_pulse_q;
  logic [ID_W-1:0]      sync_id_q, sync_id_d;
  logic [CTR_WIDTH-1:0] stretch_q, stretch_d;
  logic                 busy_q, pending_any_q;

  logic [NUM_REQ-1:0]   pend_nz;
  logic [NUM_REQ-1:0]   pend_nz_next;
  logic [NUM_REQ-1:0]   grant_vec;
  logic                 any_pend;
  logic                 grant;
  logic                 win_valid;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      cand;
  logic [CTR_WIDTH-1:0] stretch_eff;

  // Per-requester flags: counter nonzero now and after this edge, and the
  // one-hot grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign pend_nz[gi]      = |pend_q[gi];
    assign pend_nz_next[gi] = |pend_d[gi];
    assign grant_vec[gi]    = grant && (win_id == ID_W'(gi));
  end

  assign any_pend = |pend_nz;

  // A zero stretch setting would give no HOLD cycle, so it is raised to 1.
  assign stretch_eff = (cfg_stretch_val == '0) ? CTR_ONE : cfg_stretch_val;

  // Round-robin search starting at last_q+1 with wrap-around. The loop runs
  // from the farthest offset to the nearest, so the nearest candidate is
  // assigned last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (pend_nz[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  // FSM next state. Grants are issued only from IDLE.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    grant      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_pend && win_valid) begin
          grant      = 1'b1;
          state_d    = HOLD;
          hold_cnt_d = stretch_eff;
        end
      end
      HOLD: begin
        if (hold_cnt_q <= CTR_ONE) begin
          gap_cnt_d = cfg_gap_val;
          state_d   = (cfg_gap_val == '0) ? IDLE : GAP;
        end else begin
          hold_cnt_d = hold_cnt_q - CTR_ONE;
        end
      end
      GAP: begin
        if (gap_cnt_q <= CTR_ONE) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - CTR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending counters. An increment and a grant in the same cycle cancel out.
  // An increment at full scale saturates and flags overflow.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_d[i]  = pend_q[i];
      ovf_set[i] = 1'b0;
      if (req_pulse[i] && !grant_vec[i]) begin
        if (pend_q[i] == PEND_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + PEND_W'(1);
        end
      end else if (!req_pulse[i] && grant_vec[i]) begin
        pend_d[i] = pend_q[i] - PEND_W'(1);
      end
    end
  end

  // Sticky overflow. A new overflow wins over a clear in the same cycle.
  assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

  // Transfer attributes are latched at grant and held until the next grant.
  assign last_d    = grant ? win_id : last_q;
  assign sync_id_d = grant ? win_id : sync_id_q;
  assign stretch_d = grant ? stretch_eff : stretch_q;

  // Control state and counters.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      last_q     <= LAST_RST;
      ovf_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // Output registers. They are computed from next-state values, so no input
  // reaches an output without passing through a flop.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      sync_pulse_q  <= 1'b0;
      sync_id_q     <= '0;
      stretch_q     <= CTR_ONE;
      busy_q        <= 1'b0;
      pending_any_q <= 1'b0;
    end else begin
      sync_pulse_q  <= grant;
      sync_id_q     <= sync_id_d;
      stretch_q     <= stretch_d;
      busy_q        <= (state_d != IDLE);
      pending_any_q <= |pend_nz_next;
    end
  end

  assign sync_pulse      = sync_pulse_q;
  assign sync_id         = sync_id_q;
  assign stretch_val_out = stretch_q;
  assign busy            = busy_q;
  assign pending_any     = pending_any_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_multi_ratio_pulse_sched.sv
// Directed testbench for multi_ratio_pulse_sched. It prints one line for each
// observed sync_pulse.
module tb_multi_ratio_pulse_sched;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int CTR_WIDTH = 10;
  localparam int PEND_W    = 3;

  logic                 clk_src;
  logic                 rst_n_src;
  logic                 enable;
  logic [NUM_REQ-1:0]   req_pulse;
  logic [CTR_WIDTH-1:0] cfg_stretch_val;
  logic [CTR_WIDTH-1:0] cfg_gap_val;
  logic [NUM_REQ-1:0]   ovf_clr;
  logic                 sync_pulse;
  logic [ID_W-1:0]      sync_id;
  logic [CTR_WIDTH-1:0] stretch_val_out;
  logic                 busy;
  logic                 pending_any;
  logic [NUM_REQ-1:0]   overflow;

  int n_vec;
  int n_err;
  int cyc;
  int pulse_cyc[$];
  int pulse_id[$];
  int pulse_sv[$];

  multi_ratio_pulse_sched #(
    .NUM_REQ  (NUM_REQ),
    .ID_W     (ID_W),
    .CTR_WIDTH(CTR_WIDTH),
    .PEND_W   (PEND_W)
  ) dut (
    .clk_src        (clk_src),
    .rst_n_src      (rst_n_src),
    .enable         (enable),
    .req_pulse      (req_pulse),
    .cfg_stretch_val(cfg_stretch_val),
    .cfg_gap_val    (cfg_gap_val),
    .ovf_clr        (ovf_clr),
    .sync_pulse     (sync_pulse),
    .sync_id        (sync_id),
    .stretch_val_out(stretch_val_out),
    .busy           (busy),
    .pending_any    (pending_any),
    .overflow       (overflow)
  );

  initial clk_src = 1'b0;
  always #5 clk_src = ~clk_src;

  // Advance one clock, sample 1ns after the edge and log any pulse.
  task automatic tick();
    @(posedge clk_src);
    #1;
    cyc++;
    if (sync_pulse === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_id.push_back(int'(sync_id));
      pulse_sv.push_back(int'(stretch_val_out));
      $display("pulse cyc=%0d id=%0d stretch=%0d", cyc, sync_id, stretch_val_out);
    end
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_id.delete();
    pulse_sv.delete();
  endtask

  task automatic test_reset();
    rst_n_src = 1'b0;
    enable = 1'b0;
    req_pulse = '0;
    ovf_clr = '0;
    cfg_stretch_val = CTR_WIDTH'(1);
    cfg_gap_val = '0;
    repeat (3) tick();
    n_vec++; if (sync_pulse !== 1'b0) begin n_err++; $display("FAIL reset_sync_pulse got=%0b exp=0", sync_pulse); end
    n_vec++; if (sync_id !== 2'd0) begin n_err++; $display("FAIL reset_sync_id got=%0d exp=0", sync_id); end
    n_vec++; if (stretch_val_out !== 10'd1) begin n_err++; $display("FAIL reset_stretch got=%0d exp=1", stretch_val_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_vec++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL reset_pending_any got=%0b exp=0", pending_any); end
    n_vec++; if (overflow !== 4'b0000) begin n_err++; $display("FAIL reset_overflow got=%b exp=0000", overflow); end
    rst_n_src = 1'b1;
    tick();
  endtask

  // All four requesters at once, then requesters 0 and 3.
  task automatic test_simultaneous();
    int c0;
    cfg_stretch_val = 10'd2;
    cfg_gap_val = 10'd1;
    enable = 1'b1;
    clear_log();
    c0 = cyc;
    req_pulse = 4'b1111;
    tick();
    req_pulse = '0;
    repeat (20) tick();
    n_vec++; if (pulse_id.size() != 4) begin n_err++; $display("FAIL simul_count got=%0d exp=4", pulse_id.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < pulse_id.size()) begin
        n_vec++; if (pulse_id[i] != i) begin n_err++; $display("FAIL simul_id[%0d] got=%0d exp=%0d", i, pulse_id[i], i); end
        n_vec++; if (pulse_cyc[i] - c0 != 2 + 4 * i) begin n_err++; $display("FAIL simul_cyc[%0d] got=%0d exp=%0d", i, pulse_cyc[i] - c0, 2 + 4 * i); end
      end
    end
    clear_log();
    c0 = cyc;
    req_pulse = 4'b1001;
    tick();
    req_pulse = '0;
    repeat (12) tick();
    n_vec++; if (pulse_id.size() != 2) begin n_err++; $display("FAIL simul2_count got=%0d exp=2", pulse_id.size()); end
    if (pulse_id.size() >= 2) begin
      n_vec++; if (pulse_id[0] != 0) begin n_err++; $display("FAIL simul2_id0 got=%0d exp=0", pulse_id[0]); end
      n_vec++; if (pulse_id[1] != 3) begin n_err++; $display("FAIL simul2_id1 got=%0d exp=3", pulse_id[1]); end
      n_vec++; if (pulse_cyc[1] - pulse_cyc[0] != 4) begin n_err++; $display("FAIL simul2_spacing got=%0d exp=4", pulse_cyc[1] - pulse_cyc[0]); end
    end
  endtask

  // One request, S=3, G=2: pulse at cycle 2, busy for cycles 2..6.
  task automatic test_single();
    logic exp_busy, exp_pulse, exp_pa;
    cfg_stretch_val = 10'd3;
    cfg_gap_val = 10'd2;
    enable = 1'b1;
    clear_log();
    req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    for (int k = 1; k <= 10; k++) begin
      exp_busy  = (k >= 2 && k <= 6);
      exp_pulse = (k == 2);
      exp_pa    = (k == 1);
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL single_busy k=%0d got=%0b exp=%0b", k, busy, exp_busy); end
      n_vec++; if (sync_pulse !== exp_pulse) begin n_err++; $display("FAIL single_pulse k=%0d got=%0b exp=%0b", k, sync_pulse, exp_pulse); end
      n_vec++; if (pending_any !== exp_pa) begin n_err++; $display("FAIL single_pending k=%0d got=%0b exp=%0b", k, pending_any, exp_pa); end
      tick();
    end
    n_vec++; if (sync_id !== 2'd0) begin n_err++; $display("FAIL single_id got=%0d exp=0", sync_id); end
    n_vec++; if (stretch_val_out !== 10'd3) begin n_err++; $display("FAIL single_stretch got=%0d exp=3", stretch_val_out); end
  endtask

  // Ten pulses on requester 2 with enable low saturate its counter at 7.
  task automatic test_saturation();
    cfg_stretch_val = 10'd2;
    cfg_gap_val = 10'd1;
    enable = 1'b0;
    clear_log();
    for (int i = 0; i < 10; i++) begin
      req_pulse = 4'b0100;
      tick();
    end
    req_pulse = '0;
    tick();
    n_vec++; if (overflow !== 4'b0100) begin n_err++; $display("FAIL sat_overflow got=%b exp=0100", overflow); end
    n_vec++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL sat_pending got=%0b exp=1", pending_any); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_busy got=%0b exp=0", busy); end
    req_pulse = 4'b0100;
    ovf_clr = 4'b0100;
    tick();
    req_pulse = '0;
    ovf_clr = '0;
    n_vec++; if (overflow !== 4'b0100) begin n_err++; $display("FAIL sat_set_wins got=%b exp=0100", overflow); end
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = '0;
    n_vec++; if (overflow !== 4'b0000) begin n_err++; $display("FAIL sat_clear got=%b exp=0000", overflow); end
    n_vec++; if (pulse_id.size() != 0) begin n_err++; $display("FAIL sat_no_issue got=%0d exp=0", pulse_id.size()); end
    enable = 1'b1;
    repeat (40) tick();
    n_vec++; if (pulse_id.size() != 7) begin n_err++; $display("FAIL sat_drain_count got=%0d exp=7", pulse_id.size()); end
    for (int i = 0; i < pulse_id.size(); i++) begin
      n_vec++; if (pulse_id[i] != 2) begin n_err++; $display("FAIL sat_drain_id[%0d] got=%0d exp=2", i, pulse_id[i]); end
    end
    n_vec++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL sat_drained got=%0b exp=0", pending_any); end
  endtask

  // S=0 acts as S=1 and G=0 gives pulses every 2 cycles. The round-robin
  // search continues from requester 3.
  task automatic test_stretch_zero();
    int c0;
    int exp_ids[4];
    exp_ids = '{3, 0, 1, 2};
    cfg_stretch_val = 10'd0;
    cfg_gap_val = 10'd0;
    enable = 1'b1;
    clear_log();
    c0 = cyc;
    req_pulse = 4'b1111;
    tick();
    req_pulse = '0;
    repeat (12) tick();
    n_vec++; if (pulse_id.size() != 4) begin n_err++; $display("FAIL s0_count got=%0d exp=4", pulse_id.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < pulse_id.size()) begin
        n_vec++; if (pulse_cyc[i] - c0 != 2 + 2 * i) begin n_err++; $display("FAIL s0_cyc[%0d] got=%0d exp=%0d", i, pulse_cyc[i] - c0, 2 + 2 * i); end
        n_vec++; if (pulse_id[i] != exp_ids[i]) begin n_err++; $display("FAIL s0_id[%0d] got=%0d exp=%0d", i, pulse_id[i], exp_ids[i]); end
        n_vec++; if (pulse_sv[i] != 1) begin n_err++; $display("FAIL s0_stretch[%0d] got=%0d exp=1", i, pulse_sv[i]); end
      end
    end
  endtask

  // Changing the stretch from 5 to 2 mid-HOLD only affects the next transfer.
  task automatic test_cfg_change();
    cfg_stretch_val = 10'd5;
    cfg_gap_val = 10'd1;
    enable = 1'b1;
    clear_log();
    req_pulse = 4'b0011;
    tick();
    req_pulse = '0;
    tick();
    cfg_stretch_val = 10'd2;
    tick();
    n_vec++; if (stretch_val_out !== 10'd5) begin n_err++; $display("FAIL cfg_hold_stretch got=%0d exp=5", stretch_val_out); end
    repeat (13) tick();
    n_vec++; if (pulse_id.size() != 2) begin n_err++; $display("FAIL cfg_count got=%0d exp=2", pulse_id.size()); end
    if (pulse_id.size() >= 2) begin
      n_vec++; if (pulse_sv[0] != 5) begin n_err++; $display("FAIL cfg_sv0 got=%0d exp=5", pulse_sv[0]); end
      n_vec++; if (pulse_sv[1] != 2) begin n_err++; $display("FAIL cfg_sv1 got=%0d exp=2", pulse_sv[1]); end
      n_vec++; if (pulse_cyc[1] - pulse_cyc[0] != 7) begin n_err++; $display("FAIL cfg_spacing got=%0d exp=7", pulse_cyc[1] - pulse_cyc[0]); end
      n_vec++; if (pulse_id[0] != 0 || pulse_id[1] != 1) begin n_err++; $display("FAIL cfg_ids got=%0d,%0d exp=0,1", pulse_id[0], pulse_id[1]); end
    end
    n_vec++; if (stretch_val_out !== 10'd2) begin n_err++; $display("FAIL cfg_hold_after got=%0d exp=2", stretch_val_out); end
  endtask

  // Reset asserted in the pulse cycle while counts 2 (req 3) and 1 (req 1)
  // are still queued.
  task automatic test_reset_mid_hold();
    int c0;
    cfg_stretch_val = 10'd4;
    cfg_gap_val = 10'd1;
    enable = 1'b0;
    clear_log();
    req_pulse = 4'b1010; tick();
    req_pulse = 4'b1000; tick();
    req_pulse = 4'b1000; tick();
    req_pulse = '0;
    enable = 1'b1;
    tick();
    n_vec++; if (sync_pulse !== 1'b1 || sync_id !== 2'd3) begin n_err++; $display("FAIL rst_pre_pulse got=%0b/%0d exp=1/3", sync_pulse, sync_id); end
    rst_n_src = 1'b0;
    #1;
    n_vec++; if (sync_pulse !== 1'b0) begin n_err++; $display("FAIL rst_async_pulse got=%0b exp=0", sync_pulse); end
    n_vec++; if (sync_id !== 2'd0) begin n_err++; $display("FAIL rst_async_id got=%0d exp=0", sync_id); end
    n_vec++; if (stretch_val_out !== 10'd1) begin n_err++; $display("FAIL rst_async_stretch got=%0d exp=1", stretch_val_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy got=%0b exp=0", busy); end
    n_vec++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL rst_async_pending got=%0b exp=0", pending_any); end
    repeat (2) tick();
    rst_n_src = 1'b1;
    clear_log();
    repeat (15) tick();
    n_vec++; if (pulse_id.size() != 0) begin n_err++; $display("FAIL rst_no_pulse got=%0d exp=0", pulse_id.size()); end
    n_vec++; if (busy !== 1'b0 || pending_any !== 1'b0) begin n_err++; $display("FAIL rst_idle got=%0b/%0b exp=0/0", busy, pending_any); end
    clear_log();
    c0 = cyc;
    req_pulse = 4'b0100;
    tick();
    req_pulse = '0;
    repeat (4) tick();
    n_vec++; if (pulse_id.size() != 1) begin n_err++; $display("FAIL rst_new_count got=%0d exp=1", pulse_id.size()); end
    if (pulse_id.size() >= 1) begin
      n_vec++; if (pulse_id[0] != 2 || pulse_cyc[0] - c0 != 2) begin n_err++; $display("FAIL rst_new_pulse got=id%0d@%0d exp=id2@2", pulse_id[0], pulse_cyc[0] - c0); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    test_reset();
    test_simultaneous();
    test_single();
    test_saturation();
    test_stretch_zero();
    test_cfg_change();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_ratio_pulse_sched.md
Name: multi_ratio_pulse_sched

Overview:
- Source-domain scheduler that shares one multi-ratio pulse synchronizer (stretcher plus 3-stage sync) between NUM_REQ event requesters.
- Queues single-cycle request pulses per requester in saturating pending counters and picks winners round-robin.
- Issues one pulse at a time to the synchronizer's sig_in, with the stretch value and a guard gap, so every pulse arrives in the destination domain as a distinct edge.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of sync_id; must equal clog2(NUM_REQ)
CTR_WIDTH, 10, width of the stretch and gap values; matches the synchronizer's counter width
PEND_W, 3, width of each per-requester pending counter

Ports:
clk_src  input  1  source clock, single clock domain
rst_n_src  input  1  asynchronous active-low reset
enable  input  1  when low, no new issue starts; a transfer already in progress completes
req_pulse  input  NUM_REQ  single-cycle event per requester; multiple bits may be high in the same cycle
cfg_stretch_val  input  CTR_WIDTH  stretch length S in cycles; 0 is treated as 1
cfg_gap_val  input  CTR_WIDTH  idle guard G in cycles after the stretch
ovf_clr  input  NUM_REQ  write-1-to-clear for the overflow bits
sync_pulse  output  1  single-cycle pulse driving the synchronizer's sig_in
sync_id  output  ID_W  index of the requester served by the current transfer
stretch_val_out  output  CTR_WIDTH  drives the synchronizer's cfg_stretch_val; stable for the whole transfer
busy  output  1  high when the FSM is not in IDLE
pending_any  output  1  high when any pending counter is nonzero
overflow  output  NUM_REQ  sticky per-requester pending-counter overflow

Behaviour:
- Reset values: sync_pulse=0, sync_id=0, stretch_val_out=1, busy=0, pending_any=0, overflow=0, all pending counters=0, FSM=IDLE, round-robin pointer last=NUM_REQ-1 (requester 0 has first priority).
- All outputs are registered. No combinational path from any input to any output.
- Pending counters:
  - req_pulse[i] increments pend[i] on the next edge.
  - Increment at 2^PEND_W-1: pend[i] holds and overflow[i] sets.
  - A grant of i decrements pend[i].
  - Increment and grant of i in the same cycle: pend[i] is unchanged.
- Overflow clear: ovf_clr[i] clears overflow[i]. If a new overflow occurs in the same cycle, set wins.
- Arbitration: round-robin over requesters with pend[i]!=0, searching from last+1 with wrap-around. last is updated to the winner at each grant.
- FSM states: IDLE, HOLD, GAP.
  - IDLE: if enable=1 and any pend!=0, grant the winner w. Next cycle: sync_pulse=1, sync_id=w, stretch_val_out=max(cfg_stretch_val,1) latched, hold_cnt=that value, state=HOLD.
  - HOLD: hold_cnt decrements each cycle. In the cycle where hold_cnt==1, go to GAP with gap_cnt=cfg_gap_val, or directly to IDLE if cfg_gap_val==0 (value sampled in that cycle).
  - GAP: gap_cnt decrements each cycle; in the cycle where gap_cnt==1, go to IDLE.
- Timing:
  - HOLD occupies S cycles starting with the pulse cycle; GAP occupies G cycles.
  - Minimum pulse-to-pulse spacing is S+G+1 cycles.
  - Latency from req_pulse in an idle block to sync_pulse is 2 cycles.
- cfg_stretch_val changes during a transfer do not affect that transfer. The new value applies at the next grant.
- sync_id and stretch_val_out hold their values until the next grant.
- Deassertion of enable mid-transfer does not abort the transfer. After it, the FSM stays in IDLE and pending counters keep accumulating.
- Asynchronous reset at any point returns every register to its reset value, including mid-HOLD; sync_pulse is 0 immediately.
- Integrators size S to at least 2x the destination/source period ratio, and keep S+G greater than or equal to 4 destination cycles.

Test Plan:
- Single request, S=3, G=2: req_pulse=0001 at cycle 0 -> sync_pulse at cycle 2 with sync_id=0, stretch_val_out=3; busy high for cycles 2..6; busy=0 and pending_any=0 from cycle 7.
- Simultaneous requests, req_pulse=1111 once, S=2, G=1 -> pulses spaced 4 cycles apart, IDs 0,1,2,3; a later req_pulse=1001 serves 0 then 3.
- Saturation, PEND_W=3: ten req_pulse[2] pulses while enable=0 -> pend[2]=7 and overflow[2]=1. enable=1 -> exactly 7 pulses with sync_id=2. ovf_clr[2] -> overflow[2]=0. ovf_clr[2] in the same cycle as a new overflow -> overflow[2] stays 1.
- cfg_stretch_val=0, G=0 -> treated as S=1; back-to-back pulses every 2 cycles; stretch_val_out=1.
- Change cfg_stretch_val from 5 to 2 during HOLD -> current transfer lasts 5 cycles; next transfer has stretch_val_out=2.
- Assert rst_n_src low mid-HOLD with pending counts 2,1 -> all outputs and counters at reset values; no sync_pulse after reset is released until a new req_pulse arrives.
